// File: rtl/sram_access_arbiter_pkg.sv
// Shared constants for the SRAM access arbiter: FSM states, requester IDs and a log2 helper.
package sram_access_arbiter_pkg;

  localparam logic IDLE     = 1'b0;
  localparam logic WAIT_ACK = 1'b1;

  localparam int NUM_REQ = 2;

  function automatic int LOG2_FUNC(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

  localparam int ID_W = LOG2_FUNC(NUM_REQ);

  localparam logic [ID_W-1:0] REQ_UPD = ID_W'(0);
  localparam logic [ID_W-1:0] REQ_SHI = ID_W'(1);

endpackage

// File: rtl/sram_access_arbiter_tag_fifo.sv
// Small first-word-fallthrough FIFO; used to remember which requester owns each outstanding read.
module fallthrough_small_fifo_old #(
  parameter int WIDTH          = 1,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      push, pop;

  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;
  assign full  = (depth == (MAX_DEPTH_BITS+1)'(DEPTH));
  assign empty = (depth == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      depth <= depth + (MAX_DEPTH_BITS+1)'(push) - (MAX_DEPTH_BITS+1)'(pop);
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

endmodule

// File: rtl/sram_access_arbiter.sv
// Two-requester round-robin arbiter in front of one SRAM controller port; read data is routed back
// to its owner through an in-order tag FIFO.
module sram_access_arbiter
  import sram_access_arbiter_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 72,
  parameter int TAG_DEPTH_BITS  = 3,
  parameter bit RR_INIT         = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       upd_rd_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] upd_rd_addr,
  output logic                       upd_rd_ack,
  output logic                       upd_rd_vld,
  input  logic                       upd_wr_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] upd_wr_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] upd_wr_data,
  output logic                       upd_wr_ack,
  input  logic                       shi_rd_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] shi_rd_addr,
  output logic                       shi_rd_ack,
  output logic                       shi_rd_vld,
  input  logic                       shi_wr_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] shi_wr_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] shi_wr_data,
  output logic                       shi_wr_ack,
  output logic [SRAM_DATA_WIDTH-1:0] rd_data,
  output logic                       sram_rd_req,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic                       sram_rd_ack,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
  input  logic                       sram_rd_vld,
  output logic                       sram_wr_req,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
  input  logic                       sram_wr_ack,
  output logic                       orphan_err
);

  localparam int AW = SRAM_ADDR_WIDTH;
  localparam int DW = SRAM_DATA_WIDTH;

  logic [NUM_REQ-1:0]         rd_req, wr_req;
  logic [NUM_REQ-1:0][AW-1:0] rd_addr, wr_addr;
  logic [NUM_REQ-1:0][DW-1:0] wr_data;

  assign rd_req  = {shi_rd_req,  upd_rd_req};
  assign wr_req  = {shi_wr_req,  upd_wr_req};
  assign rd_addr = {shi_rd_addr, upd_rd_addr};
  assign wr_addr = {shi_wr_addr, upd_wr_addr};
  assign wr_data = {shi_wr_data, upd_wr_data};

  logic [NUM_REQ-1:0]         slot_vld, slot_wr;
  logic [NUM_REQ-1:0][AW-1:0] slot_addr;
  logic [NUM_REQ-1:0][DW-1:0] slot_data;

  logic                state_q, state_d;
  logic [ID_W-1:0]     rr, cur_id, grant_id;
  logic                cur_wr, grant_vld, done;
  logic [NUM_REQ-1:0]  eligible, rd_ack_d, wr_ack_d, rd_ack_q, wr_ack_q;
  logic                tag_full, tag_empty;
  logic [ID_W-1:0]     tag_head;

  // Reads need a free tag entry before issue; writes never wait on the FIFO.
  assign eligible = slot_vld & (slot_wr | {NUM_REQ{~tag_full}});
  assign done     = (state_q == WAIT_ACK) & (cur_wr ? sram_wr_ack : sram_rd_ack);

  // Pending slots: load only when empty, write wins over a simultaneous read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld  <= '0;
      slot_wr   <= '0;
      slot_addr <= '0;
      slot_data <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!slot_vld[i] && (rd_req[i] || wr_req[i])) begin
          slot_vld[i]  <= 1'b1;
          slot_wr[i]   <= wr_req[i];
          slot_addr[i] <= wr_req[i] ? wr_addr[i] : rd_addr[i];
          slot_data[i] <= wr_data[i];
        end else if (done && (cur_id == ID_W'(i))) begin
          slot_vld[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_id  = rr;
    case (state_q)
      IDLE: if (|eligible) begin
        grant_vld = 1'b1;
        grant_id  = (&eligible) ? rr : (eligible[REQ_SHI] ? REQ_SHI : REQ_UPD);
        state_d   = WAIT_ACK;
      end
      default: if (done) state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ack_d = '0;
    wr_ack_d = '0;
    if (done) begin
      if (cur_wr) wr_ack_d[cur_id] = 1'b1;
      else        rd_ack_d[cur_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_rd_req  <= 1'b0;
      sram_wr_req  <= 1'b0;
      sram_rd_addr <= '0;
      sram_wr_addr <= '0;
      sram_wr_data <= '0;
      cur_id       <= REQ_UPD;
      cur_wr       <= 1'b0;
      rr           <= ID_W'(RR_INIT);
      rd_ack_q     <= '0;
      wr_ack_q     <= '0;
      orphan_err   <= 1'b0;
    end else begin
      sram_rd_req <= grant_vld & ~slot_wr[grant_id];
      sram_wr_req <= grant_vld &  slot_wr[grant_id];
      if (grant_vld) begin
        cur_id <= grant_id;
        cur_wr <= slot_wr[grant_id];
        if (slot_wr[grant_id]) begin
          sram_wr_addr <= slot_addr[grant_id];
          sram_wr_data <= slot_data[grant_id];
        end else begin
          sram_rd_addr <= slot_addr[grant_id];
        end
      end
      rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d;
      if (done) rr <= ~cur_id;
      if (sram_rd_vld && tag_empty) orphan_err <= 1'b1;
    end
  end

  fallthrough_small_fifo_old #(
    .WIDTH          (ID_W),
    .MAX_DEPTH_BITS (TAG_DEPTH_BITS)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (done & ~cur_wr),
    .din   (cur_id),
    .rd_en (sram_rd_vld),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign rd_data    = sram_rd_data;
  assign upd_rd_vld = sram_rd_vld & ~tag_empty & (tag_head == REQ_UPD);
  assign shi_rd_vld = sram_rd_vld & ~tag_empty & (tag_head == REQ_SHI);
  assign upd_rd_ack = rd_ack_q[REQ_UPD];
  assign shi_rd_ack = rd_ack_q[REQ_SHI];
  assign upd_wr_ack = wr_ack_q[REQ_UPD];
  assign shi_wr_ack = wr_ack_q[REQ_SHI];

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: capture, round-robin, tag routing, drop rules, orphan, reset.
module tb_sram_access_arbiter;

  localparam int AW = 19;
  localparam int DW = 72;

  logic clk = 1'b0;
  logic reset;
  logic upd_rd_req, upd_wr_req, shi_rd_req, shi_wr_req;
  logic [AW-1:0] upd_rd_addr, upd_wr_addr, shi_rd_addr, shi_wr_addr;
  logic [DW-1:0] upd_wr_data, shi_wr_data;
  logic upd_rd_ack, upd_rd_vld, upd_wr_ack, shi_rd_ack, shi_rd_vld, shi_wr_ack;
  logic [DW-1:0] rd_data, sram_rd_data, sram_wr_data;
  logic sram_rd_req, sram_wr_req, sram_rd_ack, sram_wr_ack, sram_rd_vld, orphan_err;
  logic [AW-1:0] sram_rd_addr, sram_wr_addr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_access_arbiter #(.SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .TAG_DEPTH_BITS(3), .RR_INIT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .upd_rd_req(upd_rd_req), .upd_rd_addr(upd_rd_addr), .upd_rd_ack(upd_rd_ack), .upd_rd_vld(upd_rd_vld),
    .upd_wr_req(upd_wr_req), .upd_wr_addr(upd_wr_addr), .upd_wr_data(upd_wr_data), .upd_wr_ack(upd_wr_ack),
    .shi_rd_req(shi_rd_req), .shi_rd_addr(shi_rd_addr), .shi_rd_ack(shi_rd_ack), .shi_rd_vld(shi_rd_vld),
    .shi_wr_req(shi_wr_req), .shi_wr_addr(shi_wr_addr), .shi_wr_data(shi_wr_data), .shi_wr_ack(shi_wr_ack),
    .rd_data(rd_data),
    .sram_rd_req(sram_rd_req), .sram_rd_addr(sram_rd_addr), .sram_rd_ack(sram_rd_ack),
    .sram_rd_data(sram_rd_data), .sram_rd_vld(sram_rd_vld),
    .sram_wr_req(sram_wr_req), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_wr_ack(sram_wr_ack), .orphan_err(orphan_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    upd_rd_req = 0; upd_wr_req = 0; shi_rd_req = 0; shi_wr_req = 0;
    upd_rd_addr = '0; upd_wr_addr = '0; shi_rd_addr = '0; shi_wr_addr = '0;
    upd_wr_data = '0; shi_wr_data = '0;
    sram_rd_ack = 0; sram_wr_ack = 0; sram_rd_vld = 0; sram_rd_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
  endtask

  // Acts as the SRAM controller: waits (bounded) for a command and acks it in the same cycle.
  task automatic serve(input int budget, output bit seen, output bit is_wr,
                       output logic [AW-1:0] addr, output logic [DW-1:0] data);
    seen = 0; is_wr = 0; addr = '0; data = '0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (sram_wr_req || sram_rd_req) begin
        seen = 1; is_wr = sram_wr_req;
        addr = sram_wr_req ? sram_wr_addr : sram_rd_addr;
        data = sram_wr_data;
        sram_wr_ack = sram_wr_req; sram_rd_ack = sram_rd_req;
        tick();
        sram_wr_ack = 0; sram_rd_ack = 0;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    logic [2*AW+DW+11-1:0] outs;
    clear_inputs();
    reset = 1;
    tick(); tick();
    outs = {upd_rd_ack, upd_rd_vld, upd_wr_ack, shi_rd_ack, shi_rd_vld, shi_wr_ack,
            sram_rd_req, sram_wr_req, orphan_err, sram_rd_addr, sram_wr_addr, sram_wr_data, 2'b00};
    n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %0h want 0", outs); end
    reset = 0;
    tick(); tick();
    n_chk++; if ({sram_rd_req, sram_wr_req} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got %b want 00", {sram_rd_req, sram_wr_req}); end
  endtask

  task automatic test_single_read();
    do_reset();
    upd_rd_req = 1; upd_rd_addr = 19'h00010;
    tick();
    upd_rd_req = 0; upd_rd_addr = '0;
    n_chk++; if (sram_rd_req !== 1'b0) begin n_fail++; $display("FAIL single_early_req: got %b want 0", sram_rd_req); end
    tick();
    n_chk++; if (sram_rd_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %b want 1", sram_rd_req); end
    n_chk++; if (sram_rd_addr !== 19'h00010) begin n_fail++; $display("FAIL single_addr: got %0h want 10", sram_rd_addr); end
    n_chk++; if (sram_wr_req !== 1'b0) begin n_fail++; $display("FAIL single_no_wr: got %b want 0", sram_wr_req); end
    tick();
    n_chk++; if (sram_rd_req !== 1'b0) begin n_fail++; $display("FAIL single_req_pulse: got %b want 0", sram_rd_req); end
    n_chk++; if (sram_rd_addr !== 19'h00010) begin n_fail++; $display("FAIL single_addr_hold: got %0h want 10", sram_rd_addr); end
    tick(); tick();
    sram_rd_ack = 1;
    #1;
    n_chk++; if (upd_rd_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_early: got %b want 0", upd_rd_ack); end
    tick();
    sram_rd_ack = 0;
    n_chk++; if ({upd_rd_ack, shi_rd_ack, upd_wr_ack, shi_wr_ack} !== 4'b1000) begin n_fail++; $display("FAIL single_ack: got %b want 1000", {upd_rd_ack, shi_rd_ack, upd_wr_ack, shi_wr_ack}); end
    tick();
    n_chk++; if (upd_rd_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0", upd_rd_ack); end
    tick();
    sram_rd_vld = 1; sram_rd_data = 72'hAB;
    #1;
    n_chk++; if ({upd_rd_vld, shi_rd_vld} !== 2'b10) begin n_fail++; $display("FAIL single_vld: got %b want 10", {upd_rd_vld, shi_rd_vld}); end
    n_chk++; if (rd_data !== 72'hAB) begin n_fail++; $display("FAIL single_rd_data: got %0h want ab", rd_data); end
    tick();
    sram_rd_vld = 0; sram_rd_data = '0;
    #1;
    n_chk++; if ({upd_rd_vld, orphan_err} !== 2'b00) begin n_fail++; $display("FAIL single_after_vld: got %b want 00", {upd_rd_vld, orphan_err}); end
  endtask

  task automatic test_contention();
    int seq[$];
    int upd_left, shi_left, shi_vlds, upd_vlds, alt_err;
    bit vld_due, first_wr, first_rd;
    logic [AW-1:0] wr_a, rd_a;
    logic [DW-1:0] wr_d;
    do_reset();
    upd_left = 15; shi_left = 15; shi_vlds = 0; upd_vlds = 0; alt_err = 0;
    vld_due = 0; first_wr = 1; first_rd = 1; wr_a = '0; rd_a = '0; wr_d = '0;
    upd_wr_req = 1; upd_wr_addr = 19'h5; upd_wr_data = 72'hD1; shi_rd_req = 1; shi_rd_addr = 19'h7;
    tick();
    // Each requester re-requests as soon as it sees its ack, keeping both slots contended.
    for (int c = 0; c < 400 && seq.size() < 32; c++) begin
      sram_rd_ack = 0; sram_wr_ack = 0; sram_rd_vld = 0; upd_wr_req = 0; shi_rd_req = 0;
      if (vld_due) begin sram_rd_vld = 1; vld_due = 0; end
      if (sram_wr_req) begin
        seq.push_back(0); sram_wr_ack = 1;
        if (first_wr) begin wr_a = sram_wr_addr; wr_d = sram_wr_data; first_wr = 0; end
      end
      if (sram_rd_req) begin
        seq.push_back(1); sram_rd_ack = 1; vld_due = 1;
        if (first_rd) begin rd_a = sram_rd_addr; first_rd = 0; end
      end
      if (upd_wr_ack && upd_left > 0) begin upd_wr_req = 1; upd_left--; end
      if (shi_rd_ack && shi_left > 0) begin shi_rd_req = 1; shi_left--; end
      #1;
      if (shi_rd_vld) shi_vlds++;
      if (upd_rd_vld) upd_vlds++;
      tick();
    end
    clear_inputs();
    sram_rd_vld = vld_due;
    #1;
    if (shi_rd_vld) shi_vlds++;
    tick();
    sram_rd_vld = 0;
    for (int i = 0; i < seq.size(); i++) if (seq[i] != (i % 2)) alt_err++;
    n_chk++; if (seq.size() !== 32) begin n_fail++; $display("FAIL cont_grants: got %0d want 32", seq.size()); end
    n_chk++; if (seq.size() < 2 || seq[0] !== 0 || seq[1] !== 1) begin n_fail++; $display("FAIL cont_first_order: got size %0d want write then read", seq.size()); end
    n_chk++; if (alt_err !== 0) begin n_fail++; $display("FAIL cont_alternation: got %0d out-of-turn grants want 0", alt_err); end
    n_chk++; if ({wr_a, wr_d} !== {19'h5, 72'hD1}) begin n_fail++; $display("FAIL cont_wr_cmd: got %0h/%0h want 5/d1", wr_a, wr_d); end
    n_chk++; if (rd_a !== 19'h7) begin n_fail++; $display("FAIL cont_rd_addr: got %0h want 7", rd_a); end
    n_chk++; if (shi_vlds !== 16 || upd_vlds !== 0) begin n_fail++; $display("FAIL cont_vld_count: got shi %0d upd %0d want 16 0", shi_vlds, upd_vlds); end
  endtask

  task automatic test_tag_routing();
    bit seen, is_wr, got9;
    logic [AW-1:0] a, addr9;
    logic [DW-1:0] d;
    int rd_seen;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin upd_rd_req = 1; upd_rd_addr = AW'(19'h100 + i); end
      else            begin shi_rd_req = 1; shi_rd_addr = AW'(19'h100 + i); end
      tick();
      upd_rd_req = 0; shi_rd_req = 0;
      serve(10, seen, is_wr, a, d);
      n_chk++; if ({seen, is_wr, a} !== {1'b1, 1'b0, AW'(19'h100 + i)}) begin n_fail++; $display("FAIL tag_issue%0d: got %b%b %0h want read %0h", i, seen, is_wr, a, 19'h100 + i); end
    end
    upd_rd_req = 1; upd_rd_addr = 19'h200;
    shi_wr_req = 1; shi_wr_addr = 19'h300; shi_wr_data = 72'hD2;
    tick();
    upd_rd_req = 0; shi_wr_req = 0;
    serve(10, seen, is_wr, a, d);
    n_chk++; if ({seen, is_wr, a, d} !== {1'b1, 1'b1, 19'h300, 72'hD2}) begin n_fail++; $display("FAIL tag_write_bypass: got %b%b %0h %0h want write 300 d2", seen, is_wr, a, d); end
    rd_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (sram_rd_req) rd_seen++;
      tick();
    end
    n_chk++; if (rd_seen !== 0) begin n_fail++; $display("FAIL tag_full_hold: got %0d reads want 0", rd_seen); end
    got9 = 0; addr9 = '0;
    for (int i = 0; i < 8; i++) begin
      if (sram_rd_req) begin got9 = 1; addr9 = sram_rd_addr; sram_rd_ack = 1; end
      sram_rd_vld = 1; sram_rd_data = DW'(i + 16);
      #1;
      n_chk++; if ({upd_rd_vld, shi_rd_vld} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL tag_route%0d: got %b want %b", i, {upd_rd_vld, shi_rd_vld}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      n_chk++; if (rd_data !== DW'(i + 16)) begin n_fail++; $display("FAIL tag_data%0d: got %0h want %0h", i, rd_data, i + 16); end
      tick();
      sram_rd_vld = 0; sram_rd_ack = 0;
    end
    n_chk++; if ({got9, addr9} !== {1'b1, 19'h200}) begin n_fail++; $display("FAIL tag_ninth_read: got %b %0h want 1 200", got9, addr9); end
    sram_rd_vld = 1; sram_rd_data = 72'h99;
    #1;
    n_chk++; if ({upd_rd_vld, shi_rd_vld} !== 2'b10) begin n_fail++; $display("FAIL tag_ninth_vld: got %b want 10", {upd_rd_vld, shi_rd_vld}); end
    tick();
    sram_rd_vld = 0;
  endtask

  task automatic test_drop_rules();
    bit seen, is_wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    do_reset();
    shi_rd_req = 1; shi_rd_addr = 19'h20;
    tick();
    shi_rd_addr = 19'h21;
    tick();
    shi_rd_req = 0; shi_rd_addr = '0;
    serve(10, seen, is_wr, a, d);
    n_chk++; if ({seen, is_wr, a} !== {1'b1, 1'b0, 19'h20}) begin n_fail++; $display("FAIL drop_first_read: got %b%b %0h want read 20", seen, is_wr, a); end
    serve(8, seen, is_wr, a, d);
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL drop_repeat_read: got extra cmd addr %0h want none", a); end
    do_reset();
    upd_rd_req = 1; upd_rd_addr = 19'h30; upd_wr_req = 1; upd_wr_addr = 19'h31; upd_wr_data = 72'hD4;
    tick();
    upd_rd_req = 0; upd_wr_req = 0;
    serve(10, seen, is_wr, a, d);
    n_chk++; if ({seen, is_wr, a, d} !== {1'b1, 1'b1, 19'h31, 72'hD4}) begin n_fail++; $display("FAIL drop_rdwr_write: got %b%b %0h %0h want write 31 d4", seen, is_wr, a, d); end
    serve(8, seen, is_wr, a, d);
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL drop_rdwr_read: got extra cmd addr %0h want none", a); end
  endtask

  task automatic test_orphan();
    do_reset();
    sram_rd_vld = 1; sram_rd_data = 72'h55;
    #1;
    n_chk++; if ({upd_rd_vld, shi_rd_vld} !== 2'b00) begin n_fail++; $display("FAIL orphan_no_vld: got %b want 00", {upd_rd_vld, shi_rd_vld}); end
    tick();
    sram_rd_vld = 0;
    n_chk++; if (orphan_err !== 1'b1) begin n_fail++; $display("FAIL orphan_set: got %b want 1", orphan_err); end
    tick(); tick(); tick();
    n_chk++; if (orphan_err !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky: got %b want 1", orphan_err); end
    do_reset();
    n_chk++; if (orphan_err !== 1'b0) begin n_fail++; $display("FAIL orphan_cleared: got %b want 0", orphan_err); end
  endtask

  task automatic test_reset_wait_ack();
    bit seen, is_wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    do_reset();
    upd_wr_req = 1; upd_wr_addr = 19'h40; upd_wr_data = 72'hD3;
    tick();
    upd_wr_req = 0;
    tick();
    n_chk++; if ({sram_wr_req, sram_wr_addr} !== {1'b1, 19'h40}) begin n_fail++; $display("FAIL rst_wr_issue: got %b %0h want 1 40", sram_wr_req, sram_wr_addr); end
    tick();
    reset = 1;
    #1;
    n_chk++; if ({sram_wr_req, sram_wr_addr, sram_wr_data} !== '0) begin n_fail++; $display("FAIL rst_async_clear: got %b %0h %0h want 0", sram_wr_req, sram_wr_addr, sram_wr_data); end
    tick();
    reset = 0;
    tick();
    sram_wr_ack = 1;
    tick();
    sram_wr_ack = 0;
    n_chk++; if (upd_wr_ack !== 1'b0) begin n_fail++; $display("FAIL rst_late_ack: got %b want 0", upd_wr_ack); end
    serve(5, seen, is_wr, a, d);
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_aborted_cmd: got cmd addr %0h want none", a); end
    shi_rd_req = 1; shi_rd_addr = 19'h44;
    tick();
    shi_rd_req = 0;
    serve(10, seen, is_wr, a, d);
    n_chk++; if ({seen, is_wr, a} !== {1'b1, 1'b0, 19'h44}) begin n_fail++; $display("FAIL rst_next_read: got %b%b %0h want read 44", seen, is_wr, a); end
    n_chk++; if (shi_rd_ack !== 1'b1) begin n_fail++; $display("FAIL rst_next_ack: got %b want 1", shi_rd_ack); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_tag_routing();
    test_drop_rules();
    test_orphan();
    test_reset_wait_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
